ascon_perm_core: RTL and testbench
==================================

ASCON_PERM_CORE -- requirements
Module: ascon_perm_core

Interface
REQ-001 SHALL have parameter: ROUNDS_MAX, 12, maximum round count and round-constant index base.
REQ-002 SHALL have port: clock_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: resetb_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start_i  input  1  request to permute state_i; sampled on rising edge.
REQ-005 SHALL have port: nrounds_i  input  4  number of rounds, sampled with start_i.
REQ-006 SHALL have port: state_i  input  320  input state; x0 = [319:256], x1, x2, x3, x4 = [63:0].
REQ-007 SHALL have port: state_o  output  320  state register contents, same word layout.
REQ-008 SHALL have port: busy_o  output  1  high while rounds are in progress.
REQ-009 SHALL have port: done_o  output  1  one-cycle pulse when state_o holds the final result.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 SHALL, in IDLE or DONE with start_i=1, load state_i into the state register, set round index i = ROUNDS_MAX - n, and go to RUN.
REQ-012 SHALL use n = nrounds_i when 1..12, and n = 12 when nrounds_i is 0 or greater than 12.
REQ-013 SHALL ignore start_i while in RUN, with no effect on state, counter or outputs.
REQ-014 SHALL apply exactly one full round per clock in RUN, in the order Pc, Ps, Pl, then increment i.
REQ-015 SHALL implement Pc as: x2[7:0] ^= {(4'hF - i[3:0]), i[3:0]}, with all other bits unchanged.
REQ-016 SHALL implement Ps as: for each column j in 0..63, 5-bit S-box input {x0[j],x1[j],x2[j],x3[j],x4[j]} (x0 = MSB), with output bits written back in the same order.
REQ-017 SHALL implement Pl as: x0^=ror(x0,19)^ror(x0,28); x1^=ror(x1,61)^ror(x1,39); x2^=ror(x2,1)^ror(x2,6); x3^=ror(x3,10)^ror(x3,17); x4^=ror(x4,7)^ror(x4,41); rotations mod 64.
REQ-018 SHALL go from RUN to DONE on the edge that applies the round with i = ROUNDS_MAX-1.
REQ-019 SHALL give latency: start sampled at edge k -> rounds applied at edges k+1..k+n -> done_o=1 for the cycle after edge k+n.
REQ-020 SHALL go from DONE to IDLE after one cycle unless start_i=1, in which case it goes to RUN (back-to-back, zero idle cycles).
REQ-021 SHALL drive busy_o=1 exactly in RUN and done_o=1 exactly in DONE.
REQ-022 SHALL hold state_o stable in IDLE and DONE, showing the last result until the next accepted start.
REQ-023 SHALL have state_o show intermediate round states during RUN, which consumers SHALL NOT use.

Reset
REQ-024 SHALL, on resetb_i=0 (asynchronous, any state including mid-RUN), set FSM=IDLE, round index=0, state register=320'h0, busy_o=0, done_o=0.
REQ-025 SHALL ignore start_i while resetb_i=0; first acceptable start is at the first rising edge after deassertion.
REQ-026 SHALL NOT pulse done_o for a permutation aborted by reset.

Structure
REQ-027 SHALL place the 320-bit state type (5 x 64-bit words), the FSM enum and ROUNDS_MAX in the shared ascon_pack package.
REQ-028 SHALL put the round datapath (Pc+Ps+Pl) in one combinational sub-module ascon_round, instantiating the existing 5-bit S-box 64 times.
REQ-029 SHALL keep the FSM, round counter and state register in ascon_perm_core; no other registers.

Verification
REQ-030 SHALL test: reset, then idle 5 cycles -> state_o=0, busy_o=0, done_o=0 throughout.
REQ-031 SHALL test: state_i=0, nrounds_i=1 -> Ps intermediate x0=x1=x3=64'h4B, x2=64'hFFFFFFFFFFFFFFB4, x4=0 (probe ascon_round); state_o equals Pl of that; done_o pulses 1 cycle after edge k+1.
REQ-032 SHALL test: state_i=0, nrounds_i=12 -> constants 0xF0,0xE1,...,0x4B used in order; state_o matches a bit-exact software model; done_o after 12 rounds, busy_o high for 12 cycles.
REQ-033 SHALL test: nrounds_i=6 and 8 -> first constants 0x96 and 0xB4 respectively; nrounds_i=0 and 15 -> identical result to 12.
REQ-034 SHALL test: start_i held high continuously -> starts accepted only in IDLE/DONE; back-to-back runs with no idle gap; mid-RUN start_i pulses have no effect.
REQ-035 SHALL test: resetb_i asserted at round 5 of 12 -> outputs zero immediately (asynchronous), no done_o; a new start after release gives a correct full result.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types for the Ascon permutation core: 320-bit state layout, FSM
// encoding, round count limit and a 64-bit rotate helper.
package ascon_pack;

  localparam int ROUNDS_MAX = 12;

  typedef logic [63:0] word_t;

  // First member lands in the MSBs, so x0 occupies [319:256].
  typedef struct packed {
    word_t x0;
    word_t x1;
    word_t x2;
    word_t x3;
    word_t x4;
  } state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic word_t ror64(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
module ascon_round
  import ascon_pack::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_round,
  output state_t     o_state
);

  logic [7:0] w_rc;
  state_t     w_pc;
  state_t     w_ps;
  word_t      w_y0, w_y1, w_y2, w_y3, w_y4;

  assign w_rc = {4'hF - i_round, i_round};

  always_comb begin
    w_pc          = i_state;
    w_pc.x2[7:0]  = i_state.x2[7:0] ^ w_rc;
  end

  for (genvar j = 0; j < 64; j++) begin : g_col
    logic [4:0] w_col_y;
    ascon_sbox u_sbox (
      .i_x ({w_pc.x0[j], w_pc.x1[j], w_pc.x2[j], w_pc.x3[j], w_pc.x4[j]}),
      .o_y (w_col_y)
    );
    assign w_y0[j] = w_col_y[4];
    assign w_y1[j] = w_col_y[3];
    assign w_y2[j] = w_col_y[2];
    assign w_y3[j] = w_col_y[1];
    assign w_y4[j] = w_col_y[0];
  end

  assign w_ps = {w_y0, w_y1, w_y2, w_y3, w_y4};

  assign o_state.x0 = w_ps.x0 ^ ror64(w_ps.x0, 19) ^ ror64(w_ps.x0, 28);
  assign o_state.x1 = w_ps.x1 ^ ror64(w_ps.x1, 61) ^ ror64(w_ps.x1, 39);
  assign o_state.x2 = w_ps.x2 ^ ror64(w_ps.x2, 1)  ^ ror64(w_ps.x2, 6);
  assign o_state.x3 = w_ps.x3 ^ ror64(w_ps.x3, 10) ^ ror64(w_ps.x3, 17);
  assign o_state.x4 = w_ps.x4 ^ ror64(w_ps.x4, 7)  ^ ror64(w_ps.x4, 41);

endmodule

// File: rtl/ascon_sbox.sv
// Ascon 5-bit S-box in bit-sliced boolean form; bit 4 is the x0 lane.
module ascon_sbox (
  input  logic [4:0] i_x,
  output logic [4:0] o_y
);

  logic w_a0, w_a1, w_a2, w_a3, w_a4;
  logic w_b0, w_b1, w_b2, w_b3, w_b4;

  assign w_a0 = i_x[4] ^ i_x[0];
  assign w_a1 = i_x[3];
  assign w_a2 = i_x[2] ^ i_x[3];
  assign w_a3 = i_x[1];
  assign w_a4 = i_x[0] ^ i_x[1];

  // Chi-like nonlinear layer on the pre-mixed lanes
  assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
  assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
  assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
  assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

  assign o_y[4] = w_b0 ^ w_b4;
  assign o_y[3] = w_b1 ^ w_b0;
  assign o_y[2] = ~w_b2;
  assign o_y[1] = w_b3 ^ w_b2;
  assign o_y[0] = w_b4;

endmodule

// File: rtl/ascon_perm_core.sv
// Iterative Ascon permutation: one round per clock, round count 1..ROUNDS_MAX,
// with back-to-back starts accepted from the DONE state.
module ascon_perm_core #(
  parameter int ROUNDS_MAX = ascon_pack::ROUNDS_MAX
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [3:0]   nrounds_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] RMAX = 4'(ROUNDS_MAX);

  ascon_pack::fsm_t   r_fsm;
  logic [3:0]         r_round;
  ascon_pack::state_t r_state;
  ascon_pack::state_t w_next;
  logic [3:0]         w_n;

  // Out-of-range round counts fall back to the full permutation
  always_comb begin
    w_n = nrounds_i;
    if (nrounds_i == 4'd0 || nrounds_i > RMAX) w_n = RMAX;
  end

  ascon_round u_round (
    .i_state (r_state),
    .i_round (r_round),
    .o_state (w_next)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= ascon_pack::IDLE;
      r_round <= 4'd0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        ascon_pack::IDLE, ascon_pack::DONE: begin
          if (start_i) begin
            r_state <= state_i;
            r_round <= RMAX - w_n;
            r_fsm   <= ascon_pack::RUN;
          end else begin
            r_fsm   <= ascon_pack::IDLE;
          end
        end
        ascon_pack::RUN: begin
          r_state <= w_next;
          r_round <= r_round + 4'd1;
          if (r_round == RMAX - 4'd1) r_fsm <= ascon_pack::DONE;
        end
        default: r_fsm <= ascon_pack::IDLE;
      endcase
    end
  end

  assign state_o = r_state;
  assign busy_o  = (r_fsm == ascon_pack::RUN);
  assign done_o  = (r_fsm == ascon_pack::DONE);

endmodule

// File: tb/tb_ascon_perm_core.sv
// Bench for ascon_perm_core: directed sequence with random states checked
// against a table-driven Ascon permutation model.
module tb_ascon_perm_core;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   nr = 4'd0;
  logic [319:0] st = '0;
  logic [319:0] so;
  logic         busy;
  logic         done;

  int vectors = 0;
  int errors  = 0;

  ascon_perm_core dut (
    .clock_i   (clk),
    .resetb_i  (rstn),
    .start_i   (start),
    .nrounds_i (nr),
    .state_i   (st),
    .state_o   (so),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                            5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                            5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                            5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  logic [7:0] RC [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                          8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  int ROT [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};

  function automatic logic [63:0] ror(input logic [63:0] w, input int r);
    return (w >> r) | (w << (64 - r));
  endfunction

  function automatic logic [319:0] ref_round(input logic [319:0] s, input int i,
                                             output logic [319:0] ps);
    logic [63:0] x [5];
    logic [4:0]  v, y;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    x[2][7:0] = x[2][7:0] ^ RC[i];
    for (int j = 0; j < 64; j++) begin
      for (int k = 0; k < 5; k++) v[4-k] = x[k][j];
      y = SBOX[v];
      for (int k = 0; k < 5; k++) x[k][j] = y[4-k];
    end
    ps = {x[0], x[1], x[2], x[3], x[4]};
    for (int k = 0; k < 5; k++) x[k] = x[k] ^ ror(x[k], ROT[k][0]) ^ ror(x[k], ROT[k][1]);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int eff_n(input logic [3:0] n);
    return (n == 4'd0 || n > 4'd12) ? 12 : int'(n);
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    logic [319:0] ps;
    for (int r = 0; r < n; r++) s = ref_round(s, 12 - n + r, ps);
    return s;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a permutation and follow it cycle by cycle through DONE and back to IDLE.
  task automatic run_and_check(input logic [319:0] s, input logic [3:0] n_in, input string tag);
    int           n;
    logic [319:0] exp, ps_exp, dummy;
    n      = eff_n(n_in);
    exp    = ref_perm(s, n);
    dummy  = ref_round(s, 12 - n, ps_exp);
    @(negedge clk);
    start = 1'b1; st = s; nr = n_in;
    @(negedge clk);
    start = 1'b0; st = rnd320(); nr = 4'($urandom_range(0, 15));
    chk({tag, "_ps0"}, dut.u_round.w_ps, ps_exp);
    for (int r = 0; r < n; r++) begin
      chk({tag, "_busy"}, {319'b0, busy}, 320'd1);
      chk({tag, "_done_low"}, {319'b0, done}, 320'd0);
      chk({tag, "_rc"}, {312'b0, dut.u_round.w_rc}, {312'b0, RC[12 - n + r]});
      @(negedge clk);
    end
    chk({tag, "_done"}, {318'b0, done, busy}, 320'd2);
    chk({tag, "_result"}, so, exp);
    @(negedge clk);
    chk({tag, "_idle"}, {318'b0, done, busy}, 320'd0);
    chk({tag, "_hold"}, so, exp);
  endtask

  initial begin
    logic [319:0] a, b, ra, rb, s;

    // Reset, then idle
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_state", so, 320'd0);
      chk("idle_busy", {319'b0, busy}, 320'd0);
      chk("idle_done", {319'b0, done}, 320'd0);
    end

    // Single round on the zero state
    @(negedge clk);
    start = 1'b1; st = '0; nr = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("r1_ps", dut.u_round.w_ps,
        {64'h4B, 64'h4B, 64'hFFFFFFFFFFFFFFB4, 64'h4B, 64'h0});
    chk("r1_busy", {319'b0, busy}, 320'd1);
    @(negedge clk);
    chk("r1_done", {318'b0, done, busy}, 320'd2);
    chk("r1_result", so, ref_perm(320'd0, 1));
    @(negedge clk);
    chk("r1_done_gone", {318'b0, done, busy}, 320'd0);

    // Full permutation on zero, partial counts, and out-of-range counts
    run_and_check(320'd0, 4'd12, "zero12");
    run_and_check(rnd320(), 4'd6, "n6");
    run_and_check(rnd320(), 4'd8, "n8");
    s = rnd320();
    run_and_check(s, 4'd0, "n0");
    run_and_check(s, 4'd15, "n15");
    for (int t = 0; t < 4; t++) run_and_check(rnd320(), 4'($urandom_range(1, 13)), "rand");

    // start_i held high: A (3 rounds) then B (5 rounds) back to back
    a = rnd320(); b = rnd320();
    ra = ref_perm(a, 3); rb = ref_perm(b, 5);
    @(negedge clk);
    start = 1'b1; st = a; nr = 4'd3;
    @(negedge clk);
    st = b; nr = 4'd5;
    chk("b2b_a_busy", {319'b0, busy}, 320'd1);
    for (int r = 1; r < 3; r++) begin
      @(negedge clk);
      chk("b2b_a_busy", {319'b0, busy}, 320'd1);
    end
    @(negedge clk);
    chk("b2b_a_done", {318'b0, done, busy}, 320'd2);
    chk("b2b_a_result", so, ra);
    @(negedge clk);
    chk("b2b_b_busy", {318'b0, done, busy}, 320'd1);
    for (int r = 1; r < 5; r++) begin
      @(negedge clk);
      chk("b2b_b_busy", {319'b0, busy}, 320'd1);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_b_done", {318'b0, done, busy}, 320'd2);
    chk("b2b_b_result", so, rb);
    @(negedge clk);
    chk("b2b_idle", {318'b0, done, busy}, 320'd0);
    chk("b2b_hold", so, rb);

    // Asynchronous reset during round 5 of 12
    @(negedge clk);
    start = 1'b1; st = rnd320(); nr = 4'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0; start = 1'b1;
    #1;
    chk("arst_state", so, 320'd0);
    chk("arst_flags", {318'b0, done, busy}, 320'd0);
    chk("arst_round", {316'b0, dut.r_round}, 320'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_hold_state", so, 320'd0);
      chk("rst_hold_flags", {318'b0, done, busy}, 320'd0);
    end
    start = 1'b0; rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_flags", {318'b0, done, busy}, 320'd0);
    end
    run_and_check(rnd320(), 4'd12, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
